// File: rtl/cc_interrupt_controller_if.sv
// Processor-side I/O port bus and interrupt handshake of the KCPSM6.
// The master is the processor; the slave is the interrupt controller.
interface cc_interrupt_controller_if;
    logic [7:0] port_id;
    logic [7:0] port_out;
    logic       write_strobe;
    logic [7:0] port_in_data;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id,
        output port_out,
        output write_strobe,
        output interrupt_ack,
        input  port_in_data,
        input  interrupt
    );

    modport slave (
        input  port_id,
        input  port_out,
        input  write_strobe,
        input  interrupt_ack,
        output port_in_data,
        output interrupt
    );
endinterface

// File: rtl/cc_interrupt_controller.sv
// Round-robin interrupt controller for the command_control KCPSM6.
// Edge-detected requests become pending bits; one enabled pending source at a
// time is presented on interrupt, serviced, and released by an EOI port write.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  S_IDLE    | nothing in service; grant the next eligible source if any
//  S_ASSERT  | interrupt driven high for grant_id, waiting for interrupt_ack
//  S_SERVICE | grant acknowledged, busy=1, waiting for an EOI write
module cc_interrupt_controller #(
    parameter int         NUM_SRC      = 4,
    parameter logic [7:0] PORT_PENDING = 8'h10,
    parameter logic [7:0] PORT_MASK    = 8'h11,
    parameter logic [7:0] PORT_STATUS  = 8'h12,
    parameter logic [7:0] PORT_EOI     = 8'h13
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        irq_req,
    cc_interrupt_controller_if.slave  bus,
    output logic [2:0]                active_id,
    output logic                      busy
);

    localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_t;

    state_t             state;
    logic [NUM_SRC-1:0] irq_q;
    logic               hist_valid;
    logic [7:0]         rise;
    logic [7:0]         pending;
    logic [7:0]         mask;
    logic [7:0]         eligible;
    logic [7:0]         pending_clr;
    logic [2:0]         ptr;
    logic [2:0]         grant_id;
    logic [2:0]         grant_next;
    logic               grant_found;
    logic [3:0]         idx_sum;
    logic               wr_pending;
    logic               wr_mask;
    logic               wr_eoi;
    logic               ack_take;

    assign wr_pending = bus.write_strobe && (bus.port_id == PORT_PENDING);
    assign wr_mask    = bus.write_strobe && (bus.port_id == PORT_MASK);
    assign wr_eoi     = bus.write_strobe && (bus.port_id == PORT_EOI);
    assign ack_take   = (state == S_ASSERT) && bus.interrupt_ack;

    // The first edge after reset only loads the history, so lines that were
    // already high while in reset are not mistaken for fresh requests.
    assign rise = hist_valid ? 8'(irq_req & ~irq_q) : 8'h00;

    assign eligible = pending & mask;

    // Clears from W1C writes and from the acknowledged grant; new rises are
    // OR-ed in afterwards so a simultaneous set wins.
    assign pending_clr = (wr_pending ? bus.port_out : 8'h00)
                       | (ack_take ? (8'h01 << grant_id) : 8'h00);

    // Round-robin search: first eligible index at or above ptr, wrapping.
    always_comb begin
        grant_next  = 3'd0;
        grant_found = 1'b0;
        idx_sum     = 4'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx_sum = {1'b0, ptr} + 4'(i);
            if (idx_sum >= 4'(NUM_SRC)) begin
                idx_sum = idx_sum - 4'(NUM_SRC);
            end
            if (!grant_found && eligible[idx_sum[2:0]]) begin
                grant_found = 1'b1;
                grant_next  = idx_sum[2:0];
            end
        end
    end

    // Request edge detection, pending and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q      <= '0;
            hist_valid <= 1'b0;
            pending    <= 8'h00;
            mask       <= 8'h00;
        end else begin
            irq_q      <= irq_req;
            hist_valid <= 1'b1;
            pending    <= (pending & ~pending_clr) | rise;
            if (wr_mask) begin
                mask <= bus.port_out & SRC_MASK;
            end
        end
    end

    // Service sequencing; grant_id is frozen from IDLE until the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            bus.interrupt <= 1'b0;
            busy          <= 1'b0;
            active_id     <= 3'd0;
            grant_id      <= 3'd0;
            ptr           <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        grant_id      <= grant_next;
                        bus.interrupt <= 1'b1;
                        state         <= S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (bus.interrupt_ack) begin
                        bus.interrupt <= 1'b0;
                        active_id     <= grant_id;
                        busy          <= 1'b1;
                        ptr           <= (grant_id == 3'(NUM_SRC - 1)) ? 3'd0 : grant_id + 3'd1;
                        state         <= S_SERVICE;
                    end
                end
                S_SERVICE: begin
                    if (wr_eoi) begin
                        busy      <= 1'b0;
                        active_id <= 3'd0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    bus.interrupt <= 1'b0;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    // Registered read mux; KCPSM6 holds port_id two cycles so one cycle of latency is hidden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.port_in_data <= 8'h00;
        end else begin
            case (bus.port_id)
                PORT_PENDING: bus.port_in_data <= pending;
                PORT_MASK:    bus.port_in_data <= mask;
                PORT_STATUS:  bus.port_in_data <= {busy, 4'b0000, active_id};
                default:      bus.port_in_data <= 8'h00;
            endcase
        end
    end

endmodule
